// File: rtl/fpdiv_ctrl.sv
// fpdiv_ctrl: valid/ready front end for the iterative f32 divider core (one pending slot, one result slot).
// Define FPDIV_CTRL_SPECIAL_EN to resolve IEEE special operands without running the core.
module fpdiv_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] QNAN           = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_n,
  input  logic [31:0] req_d,
  input  logic [1:0]  req_rm,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_q,
  output logic [2:0]  rsp_flags,
  output logic        core_start,
  output logic [31:0] core_n,
  output logic [31:0] core_d,
  output logic [1:0]  core_rm,
  output logic        core_abort,
  input  logic        core_done,
  input  logic [31:0] core_q
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {IDLE, RUN} state_e;

  typedef struct packed {
    logic        hit;
    logic [2:0]  flags;
    logic [31:0] q;
  } special_t;

  state_e           state_q, state_d;
  logic             pend_valid_q, pend_valid_d;
  logic [31:0]      pend_n_q, pend_n_d;
  logic [31:0]      pend_d_q, pend_d_d;
  logic [1:0]       pend_rm_q, pend_rm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             core_start_q, core_start_d;
  logic             core_abort_q, core_abort_d;
  logic [31:0]      core_n_q, core_n_d;
  logic [31:0]      core_d_q, core_d_d;
  logic [1:0]       core_rm_q, core_rm_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_q_q, rsp_q_d;
  logic [2:0]       rsp_flags_q, rsp_flags_d;
  logic             spc_valid_q, spc_valid_d;
  logic [31:0]      spc_q_q, spc_q_d;
  logic [2:0]       spc_flags_q, spc_flags_d;

  logic     accept;
  logic     slot_free;
  logic     issue;
  special_t spc;

`ifdef FPDIV_CTRL_SPECIAL_EN
  // Priority: invalid first, then divide-by-zero, then exact zero, then exact infinity.
  function automatic special_t classify(input logic [31:0] n, input logic [31:0] d);
    special_t r;
    logic     s, n_nan, d_nan, n_inf, d_inf, n_zero, d_zero;
    s      = n[31] ^ d[31];
    n_nan  = (n[30:23] == 8'hFF) && (n[22:0] != 23'h0);
    d_nan  = (d[30:23] == 8'hFF) && (d[22:0] != 23'h0);
    n_inf  = (n[30:23] == 8'hFF) && (n[22:0] == 23'h0);
    d_inf  = (d[30:23] == 8'hFF) && (d[22:0] == 23'h0);
    n_zero = (n[30:0] == 31'h0);
    d_zero = (d[30:0] == 31'h0);
    r      = '0;
    if (n_nan || d_nan || (n_zero && d_zero) || (n_inf && d_inf)) begin
      r.hit   = 1'b1;
      r.flags = 3'b001;
      r.q     = QNAN;
    end else if (d_zero) begin
      r.hit   = 1'b1;
      r.flags = 3'b010;
      r.q     = {s, 8'hFF, 23'h0};
    end else if (n_zero || d_inf) begin
      r.hit   = 1'b1;
      r.q     = {s, 31'h0};
    end else if (n_inf) begin
      r.hit   = 1'b1;
      r.q     = {s, 8'hFF, 23'h0};
    end
    return r;
  endfunction

  assign spc = classify(pend_n_q, pend_d_q);
`else
  assign spc = '0;
`endif

  assign accept    = req_valid & ~pend_valid_q;
  assign slot_free = ~rsp_valid_q | rsp_ready;

  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_n_d     = pend_n_q;
    pend_d_d     = pend_d_q;
    pend_rm_d    = pend_rm_q;
    cnt_d        = cnt_q;
    core_start_d = 1'b0;
    core_abort_d = 1'b0;
    core_n_d     = core_n_q;
    core_d_d     = core_d_q;
    core_rm_d    = core_rm_q;
    rsp_valid_d  = rsp_valid_q & ~rsp_ready;
    rsp_q_d      = rsp_q_q;
    rsp_flags_d  = rsp_flags_q;
    spc_valid_d  = 1'b0;
    spc_q_d      = spc_q_q;
    spc_flags_d  = spc_flags_q;
    issue        = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pend_valid_q && slot_free && !spc_valid_q) begin
          issue = 1'b1;
          if (spc.hit) begin
            spc_valid_d = 1'b1;
            spc_q_d     = spc.q;
            spc_flags_d = spc.flags;
          end else begin
            core_n_d     = pend_n_q;
            core_d_d     = pend_d_q;
            core_rm_d    = pend_rm_q;
            core_start_d = 1'b1;
            state_d      = RUN;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (core_done) begin
          rsp_valid_d = 1'b1;
          rsp_q_d     = core_q;
          rsp_flags_d = 3'b000;
          cnt_d       = '0;
          state_d     = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          core_abort_d = 1'b1;
          rsp_valid_d  = 1'b1;
          rsp_q_d      = QNAN;
          rsp_flags_d  = 3'b100;
          cnt_d        = '0;
          state_d      = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    // The special stage only ever fires after the slot was seen free with IDLE held.
    if (spc_valid_q) begin
      rsp_valid_d = 1'b1;
      rsp_q_d     = spc_q_q;
      rsp_flags_d = spc_flags_q;
    end

    if (accept) begin
      pend_valid_d = 1'b1;
      pend_n_d     = req_n;
      pend_d_d     = req_d;
      pend_rm_d    = req_rm;
    end else if (issue) begin
      pend_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pend_valid_q <= 1'b0;
      pend_n_q     <= '0;
      pend_d_q     <= '0;
      pend_rm_q    <= '0;
      cnt_q        <= '0;
      core_start_q <= 1'b0;
      core_abort_q <= 1'b0;
      core_n_q     <= '0;
      core_d_q     <= '0;
      core_rm_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_q_q      <= '0;
      rsp_flags_q  <= '0;
      spc_valid_q  <= 1'b0;
      spc_q_q      <= '0;
      spc_flags_q  <= '0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_n_q     <= pend_n_d;
      pend_d_q     <= pend_d_d;
      pend_rm_q    <= pend_rm_d;
      cnt_q        <= cnt_d;
      core_start_q <= core_start_d;
      core_abort_q <= core_abort_d;
      core_n_q     <= core_n_d;
      core_d_q     <= core_d_d;
      core_rm_q    <= core_rm_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_q_q      <= rsp_q_d;
      rsp_flags_q  <= rsp_flags_d;
      spc_valid_q  <= spc_valid_d;
      spc_q_q      <= spc_q_d;
      spc_flags_q  <= spc_flags_d;
    end
  end

  assign req_ready  = ~pend_valid_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_q      = rsp_q_q;
  assign rsp_flags  = rsp_flags_q;
  assign core_start = core_start_q;
  assign core_abort = core_abort_q;
  assign core_n     = core_n_q;
  assign core_d     = core_d_q;
  assign core_rm    = core_rm_q;

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// Bench for fpdiv_ctrl: transaction scoreboard, a behavioural divider-core stand-in and directed vectors.
// Special-operand expectations follow FPDIV_CTRL_SPECIAL_EN when it is defined for the build.
module tb_fpdiv_ctrl;
  localparam int          TO = 16;
  localparam logic [31:0] QN = 32'h7FC00000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready;
  logic [31:0] req_n, req_d;
  logic [1:0]  req_rm;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_q;
  logic [2:0]  rsp_flags;
  logic        core_start, core_abort, core_done;
  logic [31:0] core_n, core_d, core_q;
  logic [1:0]  core_rm;

  always #5 clk = ~clk;

  fpdiv_ctrl #(.TIMEOUT_CYCLES(TO), .QNAN(QN)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_n(req_n), .req_d(req_d), .req_rm(req_rm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_q(rsp_q), .rsp_flags(rsp_flags),
    .core_start(core_start), .core_n(core_n), .core_d(core_d), .core_rm(core_rm),
    .core_abort(core_abort), .core_done(core_done), .core_q(core_q)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: expected responses {flags, q}; expected core issues {n, d, rm} with core delay.
  logic [34:0] exp_q[$];
  logic [65:0] iss_q[$];
  int          dly_q[$];

  int          acc_edge = 0, start_cyc = -1, done_cyc = -1, abort_cyc = -1, new_cyc = -1;
  int          start_cnt = 0, rsp_cnt = 0;
  logic [31:0] last_q = '0;
  logic [2:0]  last_f = '0;
  logic        busy = 1'b0;
  logic        inject_done = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] core_fn(input logic [31:0] n, input logic [31:0] d);
    if (n == 32'h3F800000 && d == 32'h40000000) return 32'h3F000000;
    return (n + d) ^ 32'h5A5A0000;
  endfunction

`ifdef FPDIV_CTRL_SPECIAL_EN
  // {hit, flags, q}
  function automatic logic [35:0] spec_model(input logic [31:0] n, input logic [31:0] d);
    logic s;
    logic nan_n, nan_d, inf_n, inf_d, z_n, z_d;
    s     = n[31] ^ d[31];
    nan_n = (n[30:23] == 8'hFF) && (n[22:0] != 0);
    nan_d = (d[30:23] == 8'hFF) && (d[22:0] != 0);
    inf_n = (n[30:0] == 31'h7F800000);
    inf_d = (d[30:0] == 31'h7F800000);
    z_n   = (n[30:0] == 0);
    z_d   = (d[30:0] == 0);
    if (nan_n || nan_d || (z_n && z_d) || (inf_n && inf_d)) return {1'b1, 3'b001, QN};
    if (z_d)          return {1'b1, 3'b010, s, 31'h7F800000};
    if (z_n || inf_d) return {1'b1, 3'b000, s, 31'h0};
    if (inf_n)        return {1'b1, 3'b000, s, 31'h7F800000};
    return '0;
  endfunction
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] n, input logic [31:0] d, input logic [1:0] rm, input int dly);
    logic [35:0] sp;
    logic        ok;
    ok        = 1'b0;
    req_n     = n;
    req_d     = d;
    req_rm    = rm;
    req_valid = 1'b1;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (req_ready) ok = 1'b1;
      tick();
    end
    req_valid = 1'b0;
    chk("req_accepted", ok, 1);
    if (ok) begin
      acc_edge = cyc;
`ifdef FPDIV_CTRL_SPECIAL_EN
      sp = spec_model(n, d);
`else
      sp = '0;
`endif
      if (sp[35]) begin
        exp_q.push_back(sp[34:0]);
      end else begin
        iss_q.push_back({n, d, rm});
        dly_q.push_back(dly);
        if (dly < 0) exp_q.push_back({3'b100, QN});
        else         exp_q.push_back({3'b000, core_fn(n, d)});
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    while (i < budget && (exp_q.size() != 0 || busy || rsp_valid || !req_ready)) begin
      tick();
      i++;
    end
    chk("idle_reached", (i < budget), 1);
  endtask

  // Divider core stand-in: checks the issued operands and answers after the requested delay.
  initial begin : core_bfm
    logic [65:0] cur;
    int          cnt;
    cur       = '0;
    cnt       = 0;
    core_done = 1'b0;
    core_q    = '0;
    forever begin
      @(negedge clk);
      core_done = 1'b0;
      if (!reset_n) begin
        busy = 1'b0;
      end else begin
        if (inject_done && !busy) begin
          core_done   = 1'b1;
          core_q      = 32'hDEAD0000;
          inject_done = 1'b0;
        end
        if (core_start) begin
          start_cnt++;
          start_cyc = cyc;
          if (iss_q.size() == 0) begin
            chk("core_start_expected", 1, 0);
          end else begin
            cur = iss_q.pop_front();
            cnt = dly_q.pop_front();
            chk("core_n", core_n, cur[65:34]);
            chk("core_d", core_d, cur[33:2]);
            chk("core_rm", {30'h0, core_rm}, {30'h0, cur[1:0]});
            busy = 1'b1;
          end
        end else if (busy) begin
          chk("core_ops_stable", ({core_n, core_d, core_rm} == cur), 1);
        end
        if (busy && cnt >= 0) begin
          if (cnt == 0) begin
            core_done = 1'b1;
            core_q    = core_fn(cur[65:34], cur[33:2]);
            done_cyc  = cyc;
            busy      = 1'b0;
          end else begin
            cnt--;
          end
        end
        if (core_abort) begin
          chk("abort_while_busy", busy, 1);
          abort_cyc = cyc;
          busy      = 1'b0;
        end
      end
    end
  end

  // Response checker: every handshake pops the scoreboard; held responses must not change.
  initial begin : compare
    logic [34:0] e;
    logic        prev_vld, prev_hs;
    logic [31:0] prev_q;
    logic [2:0]  prev_f;
    prev_vld = 1'b0;
    prev_hs  = 1'b0;
    prev_q   = '0;
    prev_f   = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_vld = 1'b0;
        prev_hs  = 1'b0;
      end else begin
        if (prev_vld && !prev_hs) begin
          chk("rsp_hold_valid", rsp_valid, 1);
          chk("rsp_hold_q", rsp_q, prev_q);
          chk("rsp_hold_flags", rsp_flags, prev_f);
        end
        if (rsp_valid && (!prev_vld || prev_hs)) new_cyc = cyc;
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            chk("rsp_expected", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_q", rsp_q, e[31:0]);
            chk("rsp_flags", rsp_flags, e[34:32]);
          end
          last_q = rsp_q;
          last_f = rsp_flags;
          rsp_cnt++;
        end
        if (core_start) begin
          chk("start_rsp_slot_empty", rsp_valid, 0);
          chk("start_req_ready", req_ready, 1);
        end
        prev_vld = rsp_valid;
        prev_hs  = rsp_valid & rsp_ready;
        prev_q   = rsp_q;
        prev_f   = rsp_flags;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no end of run, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int a, s0, r0;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_n     = '0;
    req_d     = '0;
    req_rm    = '0;
    rsp_ready = 1'b1;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_q", rsp_q, 0);
    chk("rst_rsp_flags", rsp_flags, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_core_abort", core_abort, 0);
    chk("rst_core_n", core_n, 0);
    chk("rst_core_d", core_d, 0);
    chk("rst_core_rm", core_rm, 0);

    // Normal operation: 1.0 / 2.0, core answers 10 cycles after start.
    send(32'h3F800000, 32'h40000000, 2'd2, 10);
    a = acc_edge;
    wait_idle(100);
    chk("norm_start_lat", start_cyc, a + 1);
    chk("norm_done_cyc", done_cyc, start_cyc + 10);
    chk("norm_rsp_lat", new_cyc, done_cyc + 1);
    chk("norm_q", last_q, 32'h3F000000);
    chk("norm_flags", last_f, 0);

    // Back-to-back with the consumer always ready.
    s0 = start_cnt;
    r0 = rsp_cnt;
    send(32'h40400000, 32'h3F800000, 2'd0, 3);
    send(32'hC0000000, 32'h40800000, 2'd1, 3);
    send(32'h41200000, 32'h40A00000, 2'd3, 0);
    wait_idle(200);
    chk("b2b_starts", start_cnt - s0, 3);
    chk("b2b_rsps", rsp_cnt - r0, 3);

    // Backpressure: the second op must wait until the first result drains.
    s0 = start_cnt;
    r0 = rsp_cnt;
    rsp_ready = 1'b0;
    send(32'h42000000, 32'h40000000, 2'd0, 2);
    send(32'h42800000, 32'h41000000, 2'd1, 2);
    repeat (20) tick();
    chk("bp_starts_held", start_cnt - s0, 1);
    chk("bp_rsp_valid", rsp_valid, 1);
    chk("bp_req_ready", req_ready, 0);
    chk("bp_no_rsp", rsp_cnt - r0, 0);
    rsp_ready = 1'b1;
    wait_idle(100);
    chk("bp_starts", start_cnt - s0, 2);
    chk("bp_rsps", rsp_cnt - r0, 2);

    // Timeout: the core never answers.
    send(32'h3F800000, 32'h40400000, 2'd0, -1);
    wait_idle(TO + 40);
    chk("to_abort_cyc", abort_cyc, start_cyc + TO);
    chk("to_rsp_cyc", new_cyc, abort_cyc);
    chk("to_q", last_q, 32'h7FC00000);
    chk("to_flags", last_f, 3'b100);

    // Special operands.
    s0 = start_cnt;
`ifdef FPDIV_CTRL_SPECIAL_EN
    send(32'h40000000, 32'h00000000, 2'd0, 1);
    a = acc_edge;
    wait_idle(50);
    chk("sp_dz_lat", new_cyc, a + 2);
    chk("sp_dz_q", last_q, 32'h7F800000);
    chk("sp_dz_flags", last_f, 3'b010);
    send(32'h7F800000, 32'h7F800000, 2'd0, 1);
    wait_idle(50);
    chk("sp_nv_q", last_q, 32'h7FC00000);
    chk("sp_nv_flags", last_f, 3'b001);
    send(32'h80000000, 32'h3F800000, 2'd0, 1);
    wait_idle(50);
    chk("sp_zero_q", last_q, 32'h80000000);
    chk("sp_zero_flags", last_f, 0);
    send(32'h7F800001, 32'h3F800000, 2'd0, 1);
    send(32'hBF800000, 32'h7F800000, 2'd0, 1);
    send(32'hFF800000, 32'h40000000, 2'd0, 1);
    wait_idle(50);
    chk("sp_no_core", start_cnt - s0, 0);
`else
    send(32'h40000000, 32'h00000000, 2'd0, 1);
    send(32'h7F800000, 32'h7F800000, 2'd0, 1);
    send(32'h80000000, 32'h3F800000, 2'd0, 1);
    wait_idle(80);
    chk("nosp_core_used", start_cnt - s0, 3);
    chk("nosp_flags", last_f, 0);
`endif

    // core_done while idle must be ignored.
    r0 = rsp_cnt;
    inject_done = 1'b1;
    repeat (6) tick();
    chk("stray_done_valid", rsp_valid, 0);
    chk("stray_done_rsps", rsp_cnt - r0, 0);

    // Reset in the middle of RUN.
    send(32'h40E00000, 32'h40000000, 2'd1, -1);
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_req_ready", req_ready, 1);
    chk("mid_rst_core_start", core_start, 0);
    exp_q.delete();
    iss_q.delete();
    dly_q.delete();
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    r0 = rsp_cnt;
    inject_done = 1'b1;
    repeat (6) tick();
    chk("late_done_valid", rsp_valid, 0);
    chk("late_done_rsps", rsp_cnt - r0, 0);
    chk("post_rst_core_n", core_n, 0);

    // Recovery after reset.
    send(32'h3F800000, 32'h40000000, 2'd0, 4);
    wait_idle(60);
    chk("recover_q", last_q, 32'h3F000000);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
